// File: rtl/upcounter_ctrl.sv
// rtl/upcounter_ctrl.sv - button debounce, STOP/RUN/CLEAR FSM and prescaled up-counter feeding the FND display path
module upcounter_ctrl #(
    parameter int DB_CYCLES = 1_000_000,
    parameter int TICK_DIV  = 10_000_000,
    parameter int MAX_VALUE = 9999
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_btn_runStop,
    input  logic        i_btn_clear,
    input  logic        i_btn_onOff,
    output logic [13:0] o_value,
    output logic        o_clear,
    output logic        o_onOff,
    output logic        o_running
);

    localparam int DB_W   = $clog2(DB_CYCLES + 1);
    localparam int TICK_W = $clog2(TICK_DIV);

    typedef enum logic [1:0] {
        ST_STOP  = 2'd0,
        ST_RUN   = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    // bit 0 = runStop, bit 1 = clear, bit 2 = onOff
    logic [2:0]      raw;
    logic [2:0]      sync1;
    logic [2:0]      sync2;
    logic [2:0]      level;
    logic [2:0]      level_d;
    logic [2:0]      press;
    logic [DB_W-1:0] db_cnt [3];

    state_t            state;
    state_t            next_state;
    logic [TICK_W-1:0] prescaler;

    assign raw   = {i_btn_onOff, i_btn_clear, i_btn_runStop};
    assign press = level & ~level_d;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            sync1   <= '0;
            sync2   <= '0;
            level   <= '0;
            level_d <= '0;
            for (int i = 0; i < 3; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync1   <= raw;
            sync2   <= sync1;
            level_d <= level;
            // Any sample agreeing with the accepted level restarts the stability window
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] != level[i]) begin
                    if (db_cnt[i] == DB_W'(DB_CYCLES - 1)) begin
                        level[i]  <= sync2[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + 1'b1;
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_STOP: begin
                if (press[1])      next_state = ST_CLEAR;
                else if (press[0]) next_state = ST_RUN;
            end
            ST_RUN: begin
                if (press[1])      next_state = ST_CLEAR;
                else if (press[0]) next_state = ST_STOP;
            end
            ST_CLEAR: next_state = ST_STOP;
            default:  next_state = ST_STOP;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state     <= ST_STOP;
            o_running <= 1'b0;
            o_clear   <= 1'b0;
            o_onOff   <= 1'b1;
            prescaler <= '0;
            o_value   <= '0;
        end else begin
            state     <= next_state;
            o_running <= (next_state == ST_RUN);
            o_clear   <= (next_state == ST_CLEAR);
            if (press[2]) begin
                o_onOff <= ~o_onOff;
            end
            // STOP holds both registers so the tick phase survives a pause
            if (state == ST_CLEAR) begin
                prescaler <= '0;
                o_value   <= '0;
            end else if (state == ST_RUN) begin
                if (prescaler == TICK_W'(TICK_DIV - 1)) begin
                    prescaler <= '0;
                    o_value   <= (o_value == 14'(MAX_VALUE)) ? 14'd0 : o_value + 14'd1;
                end else begin
                    prescaler <= prescaler + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_upcounter_ctrl.sv
// tb/tb_upcounter_ctrl.sv - self-checking bench for upcounter_ctrl
module tb_upcounter_ctrl;

    localparam int DBC  = 4;
    localparam int TDIV = 5;
    localparam int MAXV = 9999;

    logic        clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        btn_rs = 1'b0;
    logic        btn_clr = 1'b0;
    logic        btn_oo = 1'b0;
    logic [13:0] o_value;
    logic        o_clear;
    logic        o_onOff;
    logic        o_running;

    upcounter_ctrl #(
        .DB_CYCLES(DBC),
        .TICK_DIV (TDIV),
        .MAX_VALUE(MAXV)
    ) dut (
        .i_clk        (clk),
        .i_reset      (i_reset),
        .i_btn_runStop(btn_rs),
        .i_btn_clear  (btn_clr),
        .i_btn_onOff  (btn_oo),
        .o_value      (o_value),
        .o_clear      (o_clear),
        .o_onOff      (o_onOff),
        .o_running    (o_running)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic rs;
        logic clr;
        logic oo;
        logic exp_run;
        logic exp_onoff;
        logic exp_clr;
    } vec_t;

    vec_t tbl[10];
    vec_t exp_q[$];

    int pass_cnt = 0;
    int total_cnt = 0;
    int cyc = 0;
    int last_cyc = 0;
    int clear_cnt = 0;
    int run_rises = 0;
    bit armed = 0;
    logic [13:0] prev_value = '0;
    logic        prev_run = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_value(input int v, input int limit);
        int n;
        n = 0;
        while (o_value != 14'(v) && n < limit) begin
            tick(1);
            n++;
        end
        check($sformatf("reach_value_%0d", v), o_value, v);
    endtask

    // Independent property watcher: while running, each change is +1 (or wrap) and 5 cycles apart
    always @(negedge clk) begin
        cyc++;
        if (o_clear === 1'b1) clear_cnt++;
        if (o_running === 1'b1 && prev_run !== 1'b1) run_rises++;
        if (o_running !== 1'b1) begin
            armed = 0;
        end else if (o_value !== prev_value) begin
            check("step_value", o_value, (prev_value == 14'(MAXV)) ? 0 : prev_value + 1);
            if (armed) check("step_spacing", cyc - last_cyc, TDIV);
            armed = 1;
            last_cyc = cyc;
        end
        prev_value = o_value;
        prev_run = o_running;
    end

    initial begin
        vec_t e;
        int   n;
        int   clr_base;

        tbl[0] = '{1, 0, 0, 1, 1, 0};
        tbl[1] = '{1, 0, 0, 0, 1, 0};
        tbl[2] = '{1, 0, 0, 1, 1, 0};
        tbl[3] = '{0, 0, 1, 1, 0, 0};
        tbl[4] = '{0, 0, 1, 1, 1, 0};
        tbl[5] = '{0, 1, 0, 0, 1, 1};
        tbl[6] = '{1, 1, 0, 0, 1, 1};
        tbl[7] = '{1, 0, 1, 1, 0, 0};
        tbl[8] = '{1, 1, 0, 0, 0, 1};
        tbl[9] = '{0, 0, 1, 0, 1, 0};

        // reset
        tick(3);
        i_reset = 1'b0;
        tick(1);
        check("rst_value", o_value, 0);
        check("rst_onoff", o_onOff, 1);
        check("rst_running", o_running, 0);
        check("rst_clear", o_clear, 0);

        // bounce then stable press: fixed latency, one transition, 12 counts in 60 cycles
        run_rises = 0;
        for (int i = 0; i < 10; i++) begin
            btn_rs = (i % 2 == 0);
            tick(1);
        end
        btn_rs = 1'b1;
        n = 0;
        while (o_running !== 1'b1 && n < 30) begin
            tick(1);
            n++;
        end
        check("press_latency", n, 7);
        tick(13);
        btn_rs = 1'b0;
        tick(47);
        check("count_after_60", o_value, 12);
        check("single_transition", run_rises, 1);
        check("still_running", o_running, 1);

        // clear and runStop together at 37
        wait_value(37, 300);
        btn_rs = 1'b1;
        btn_clr = 1'b1;
        tick(7);
        check("both_clear_pulse", o_clear, 1);
        check("both_running", o_running, 0);
        tick(1);
        check("both_clear_end", o_clear, 0);
        check("both_value", o_value, 0);
        check("both_stop", o_running, 0);
        btn_rs = 1'b0;
        btn_clr = 1'b0;
        tick(10);

        // press table
        for (int k = 0; k < 10; k++) begin
            btn_rs = tbl[k].rs;
            btn_clr = tbl[k].clr;
            btn_oo = tbl[k].oo;
            exp_q.push_back(tbl[k]);
            tick(7);
            e = exp_q.pop_front();
            check($sformatf("vec%0d_running", k), o_running, e.exp_run);
            check($sformatf("vec%0d_onoff", k), o_onOff, e.exp_onoff);
            check($sformatf("vec%0d_clear", k), o_clear, e.exp_clr);
            tick(1);
            if (e.exp_clr) begin
                check($sformatf("vec%0d_clear_end", k), o_clear, 0);
                check($sformatf("vec%0d_value", k), o_value, 0);
            end
            btn_rs = 1'b0;
            btn_clr = 1'b0;
            btn_oo = 1'b0;
            tick(10);
        end

        // runStop pulse landing in the CLEAR cycle is dropped
        btn_clr = 1'b1;
        tick(1);
        btn_rs = 1'b1;
        tick(6);
        check("drop_clear_pulse", o_clear, 1);
        tick(1);
        check("drop_clear_end", o_clear, 0);
        check("drop_running", o_running, 0);
        tick(1);
        check("drop_running_late", o_running, 0);
        btn_rs = 1'b0;
        btn_clr = 1'b0;
        tick(10);

        // wrap MAX_VALUE -> 0 without o_clear
        btn_rs = 1'b1;
        tick(8);
        check("wrap_running", o_running, 1);
        btn_rs = 1'b0;
        wait_value(MAXV, 60000);
        clr_base = clear_cnt;
        n = 0;
        while (o_value == 14'(MAXV) && n < 10) begin
            tick(1);
            n++;
        end
        check("wrap_cycles", n, TDIV);
        check("wrap_value", o_value, 0);
        check("wrap_no_clear", clear_cnt - clr_base, 0);

        // reset mid-RUN with display off
        btn_oo = 1'b1;
        tick(7);
        check("off_before_reset", o_onOff, 0);
        btn_oo = 1'b0;
        tick(3);
        i_reset = 1'b1;
        tick(1);
        check("midrst_value", o_value, 0);
        check("midrst_onoff", o_onOff, 1);
        check("midrst_running", o_running, 0);
        check("midrst_clear", o_clear, 0);
        i_reset = 1'b0;
        tick(10);
        check("postrst_running", o_running, 0);
        check("postrst_value", o_value, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
